// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache refill/writeback sequencer.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned WORD_BYTES     = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Which cache owns the in-flight transaction
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_refill_arbiter.sv
// Arbitrates I/D cache misses onto one memory port: optional dirty writeback,
// then line refill, then a one-cycle done pulse. D-cache wins ties.
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          CpuRst,
    input  logic                          ic_miss,
    input  logic [ADDR_W-1:0]             ic_addr,
    input  logic                          dc_miss,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic                          dc_dirty,
    input  logic [ADDR_W-1:0]             dc_wb_addr,
    input  logic [DATA_W-1:0]             dc_wb_data,
    output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          refill_we,
    output logic                          refill_sel,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
    output logic [DATA_W-1:0]             refill_data,
    output logic                          ic_done,
    output logic                          dc_done,
    output logic                          ICacheMiss,
    output logic                          DCacheMiss
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    state_e             state, state_nxt;
    owner_e             owner, owner_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  base, base_nxt;
    logic [ADDR_W-1:0]  beat_off;

    // Byte offset of the current beat within the line (wraps modulo 2^ADDR_W)
    assign beat_off = ADDR_W'(cnt) * ADDR_W'(WORD_BYTES);

    // State, owner, beat counter and latched refill base
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state <= IDLE;
            owner <= OWN_I;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            base  <= base_nxt;
        end
    end

    // Next-state and memory/refill/done decode
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        base_nxt    = base;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_idx      = '0;
        refill_we   = 1'b0;
        refill_sel  = 1'b0;
        refill_idx  = '0;
        refill_data = '0;
        ic_done     = 1'b0;
        dc_done     = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (dc_miss) begin
                    owner_nxt = OWN_D;
                    base_nxt  = dc_addr;
                    state_nxt = dc_dirty ? WB : RD;
                end else if (ic_miss) begin
                    owner_nxt = OWN_I;
                    base_nxt  = ic_addr;
                    state_nxt = RD;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dc_wb_addr + beat_off;
                mem_wdata = dc_wb_data;
                wb_idx    = cnt;
                if (mem_ack) begin
                    cnt_nxt = cnt + IDX_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = base + beat_off;
                if (mem_ack) begin
                    refill_we   = 1'b1;
                    refill_sel  = owner;
                    refill_idx  = cnt;
                    refill_data = mem_rdata;
                    cnt_nxt     = cnt + IDX_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                ic_done   = (owner == OWN_I);
                dc_done   = (owner == OWN_D);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pipeline stall requests released on the completion pulse
    assign ICacheMiss = ic_miss & ~ic_done;
    assign DCacheMiss = dc_miss & ~dc_done;

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Sequences cache-line refills and dirty writebacks for the instruction and data caches over the single shared main-memory port. It sits beside HarzardUnit and drives its ICacheMiss/DCacheMiss stall inputs until the serviced line is installed. When both caches miss in the same cycle, it grants the data cache first.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width; memory beat = one word
- LINE_WORDS, 4, words per cache line; power of two, ≥2

Ports:
- clk  in  1  rising-edge clock
- CpuRst  in  1  synchronous, active-high reset
- ic_miss  in  1  I-cache miss request; held until ic_done
- ic_addr  in  ADDR_W  line-aligned refill address; stable while ic_miss
- dc_miss  in  1  D-cache miss request; held until dc_done
- dc_addr  in  ADDR_W  line-aligned refill address
- dc_dirty  in  1  victim line must be written back first
- dc_wb_addr  in  ADDR_W  line-aligned victim address
- dc_wb_data  in  DATA_W  victim word selected by wb_idx (combinational read)
- wb_idx  out  log2(LINE_WORDS)  victim word index
- mem_req, mem_we  out  1  memory request / write enable
- mem_addr  out  ADDR_W  word byte-address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  beat accepted (write) / mem_rdata valid (read)
- mem_rdata  in  DATA_W  read data
- refill_we  out  1  write refill word into selected cache
- refill_sel  out  1  0 = I-cache, 1 = D-cache
- refill_idx  out  log2(LINE_WORDS)  word index within line
- refill_data  out  DATA_W  word to install
- ic_done, dc_done  out  1  one-cycle completion pulse
- ICacheMiss, DCacheMiss  out  1  stall requests to HarzardUnit

## Operation
- States: IDLE, WB, RD, DONE. Registers: state, owner (0=I, 1=D), beat counter cnt (log2(LINE_WORDS) bits), latched base address.
- IDLE: if dc_miss → owner=D, latch dc_addr, next = dc_dirty ? WB : RD; else if ic_miss → owner=I, latch ic_addr, next = RD. cnt=0.
- WB (owner D only): mem_req=1, mem_we=1, mem_addr = dc_wb_addr + 4·cnt, mem_wdata = dc_wb_data, wb_idx=cnt. On mem_ack: cnt++; on last beat (cnt==LINE_WORDS-1) cnt wraps to 0 and next = RD.
- RD: mem_req=1, mem_we=0, mem_addr = base + 4·cnt. On mem_ack: refill_we=1, refill_idx=cnt, refill_data=mem_rdata, refill_sel=owner (combinational, same cycle); cnt++; on last beat next = DONE.
- DONE: pulse ic_done or dc_done per owner, next = IDLE. A request still pending (e.g. ic_miss while D was served) is granted in the following IDLE cycle.
- ICacheMiss = ic_miss & ~ic_done; DCacheMiss = dc_miss & ~dc_done.
- Address arithmetic is modulo 2^ADDR_W; the increment is 4 bytes per word.
- A miss line dropped mid-transaction is ignored; the transaction still completes.

## Timing
- Reset values: state=IDLE, cnt=0, owner=0. mem_req, mem_we, refill_we, ic_done, dc_done are 0; all address/data outputs are 0.
- CpuRst mid-transaction: IDLE at the next edge. The in-flight beat is abandoned and mem_req drops that edge.
- mem_req rises one cycle after the miss is sampled in IDLE. It stays high across WB→RD with addr/we/wdata stable until mem_ack.
- Zero-wait memory (ack every cycle): clean refill = 1 (IDLE) + LINE_WORDS + 1 (DONE) cycles from miss to done. Dirty refill adds LINE_WORDS cycles.
- Memory stalls: a beat without mem_ack holds all outputs and cnt.
- A done pulse coincides with mem_req=0. The cache drops the miss on the next edge.

## Structure
- Shared package cache_pkg: state enum {IDLE, WB, RD, DONE}, owner encoding, LINE_WORDS/ADDR_W defaults, WORD_BYTES=4.
- Single module: one FSM plus beat counter. No sub-module is warranted.

## Test plan
- Clean I-miss, ic_addr=0x1000, ack every cycle → reads at 0x1000/04/08/0C; refill_sel=0, idx 0..3; ic_done at cycle 6; ICacheMiss low after.
- Dirty D-miss, wb 0x2000, refill 0x3000 → 4 writes (mem_we=1) at 0x2000..0x200C, then 4 reads at 0x3000..0x300C; dc_done at cycle 10.
- ic_miss and dc_miss same cycle → D served first, dc_done, then I granted the next IDLE cycle; ic_done follows.
- mem_ack low for 3 cycles on beat 2 → mem_addr and cnt hold; no refill_we during the wait; total latency +3.
- CpuRst during RD beat 1 → next edge IDLE, mem_req=0, no done pulse; a new ic_miss after reset refills from word 0.
- ic_addr=0xFFFFFFF0 → addresses wrap correctly through 0xFFFFFFFC; no overflow into other fields.
